// File: rtl/updown_count_sequencer.sv
// Sequences an external up/down counter through a programmed triangle profile:
// clear, count up to top, dwell at the peak, count down to 0, repeated for `loops` passes.
module updown_count_sequencer #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned DWELL_W = 4,
   parameter int unsigned LOOP_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   top,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [LOOP_W-1:0]  loops,
   input  logic [WIDTH-1:0]   count,
   output logic               cnt_enable,
   output logic               cnt_up_down,
   output logic               cnt_reset,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [LOOP_W-1:0]  loop_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_UP,
      S_DWELL,
      S_DOWN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [WIDTH-1:0]     top_q;
   logic [DWELL_W-1:0]   dwell_q;
   logic [LOOP_W-1:0]    loops_q;
   logic [DWELL_W-1:0]   dwell_cnt;

   logic accept;
   logic degenerate;
   logic at_top;
   logic at_bottom;
   logic last_pass;

   assign accept     = start & ~abort;
   assign degenerate = (loops == '0) | (top == '0);
   assign at_top     = count >= top_q;
   assign at_bottom  = count == '0;
   assign last_pass  = (loop_idx + LOOP_W'(1)) == loops_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Latched profile, dwell countdown and completed-pass counter
   always_ff @(posedge clk) begin
      if (reset) begin
         top_q     <= '0;
         dwell_q   <= '0;
         loops_q   <= '0;
         dwell_cnt <= '0;
         loop_idx  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  top_q    <= top;
                  dwell_q  <= dwell;
                  loops_q  <= loops;
                  loop_idx <= '0;
               end
            end
            S_UP: begin
               if (!abort && at_top) dwell_cnt <= dwell_q;
            end
            S_DWELL: begin
               if (!abort) dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
            S_DOWN: begin
               if (!abort && at_bottom) loop_idx <= loop_idx + LOOP_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Next-state logic; abort wins over every in-sequence transition
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = degenerate ? S_DONE : S_CLEAR;
         end
         S_CLEAR: begin
            state_nxt = abort ? S_ABORT : S_UP;
         end
         S_UP: begin
            if (abort)       state_nxt = S_ABORT;
            else if (at_top) state_nxt = (dwell_q == '0) ? S_DOWN : S_DWELL;
         end
         S_DWELL: begin
            if (abort)                            state_nxt = S_ABORT;
            else if (dwell_cnt == DWELL_W'(1))    state_nxt = S_DOWN;
         end
         S_DOWN: begin
            if (abort)          state_nxt = S_ABORT;
            else if (at_bottom) state_nxt = last_pass ? S_DONE : S_UP;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ABORT: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode; enable is never given at a boundary in the boundary direction
   always_comb begin
      cnt_enable  = 1'b0;
      cnt_up_down = 1'b0;
      cnt_reset   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      aborted     = 1'b0;
      case (state)
         S_IDLE:  busy = 1'b0;
         S_CLEAR: cnt_reset = 1'b1;
         S_UP: begin
            cnt_up_down = 1'b1;
            cnt_enable  = ~abort & ~at_top;
         end
         S_DWELL: cnt_up_down = 1'b1;
         S_DOWN:  cnt_enable = ~abort & ~at_bottom;
         S_DONE:  done = 1'b1;
         S_ABORT: begin
            aborted   = 1'b1;
            cnt_reset = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Randomized bench for updown_count_sequencer: a per-cycle expected trace is built from
// the triangle profile arithmetic and compared against the DUT driving a behavioural counter.
module tb_updown_count_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [3:0] top;
   logic [3:0] dwell;
   logic [3:0] loops;
   logic [3:0] count;
   logic       cnt_enable;
   logic       cnt_up_down;
   logic       cnt_reset;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [3:0] loop_idx;
   logic       ctr_clr;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       ab;
      logic       rst;
      logic       en;
      logic       ud;
      logic [3:0] li;
      logic [3:0] cnt;
   } exp_t;

   exp_t       tr[$];
   logic [3:0] prev;

   always #5 clk = ~clk;

   updown_count_sequencer #(.WIDTH(4), .DWELL_W(4), .LOOP_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .top(top), .dwell(dwell), .loops(loops), .count(count),
      .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down), .cnt_reset(cnt_reset),
      .busy(busy), .done(done), .aborted(aborted), .loop_idx(loop_idx)
   );

   // External 4-bit synchronous up/down counter
   always @(posedge clk) begin
      if (ctr_clr || cnt_reset) count <= 4'd0;
      else if (cnt_enable)      count <= cnt_up_down ? count + 4'd1 : count - 4'd1;
   end

   function automatic exp_t mk(input logic b, input logic d, input logic a, input logic r,
                               input logic e, input logic u, input logic [3:0] li,
                               input logic [3:0] c);
      exp_t x;
      x.busy = b; x.done = d; x.ab = a; x.rst = r; x.en = e; x.ud = u; x.li = li; x.cnt = c;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected cycle-by-cycle trace, starting in the cycle after start is accepted
   task automatic build(input int t, input int d, input int l, input logic [3:0] pc);
      tr.delete();
      if (t == 0 || l == 0) begin
         tr.push_back(mk(1, 1, 0, 0, 0, 0, 4'd0, pc));
         tr.push_back(mk(0, 0, 0, 0, 0, 0, 4'd0, pc));
         return;
      end
      tr.push_back(mk(1, 0, 0, 1, 0, 0, 4'd0, pc));
      for (int p = 0; p < l; p++) begin
         for (int v = 0; v <= t; v++)  tr.push_back(mk(1, 0, 0, 0, v < t, 1, 4'(p), 4'(v)));
         for (int i = 0; i < d; i++)   tr.push_back(mk(1, 0, 0, 0, 0, 1, 4'(p), 4'(t)));
         for (int v = t; v >= 0; v--)  tr.push_back(mk(1, 0, 0, 0, v != 0, 0, 4'(p), 4'(v)));
      end
      tr.push_back(mk(1, 1, 0, 0, 0, 0, 4'(l), 4'd0));
      tr.push_back(mk(0, 0, 0, 0, 0, 0, 4'(l), 4'd0));
   endtask

   // ab: abort index (-1 none, -2 random); rs: reset index (-1 none)
   task automatic run(input string name, input int t, input int d, input int l,
                      input int ab, input int rs);
      exp_t       e;
      int         n;
      logic [3:0] nc;
      build(t, d, l, prev);
      if (ab == -2)
         ab = (tr.size() > 2 && $urandom_range(0, 2) == 0) ? $urandom_range(0, tr.size() - 3) : -1;
      if (ab >= 0) begin
         e = tr[ab];
         tr = tr[0:ab];
         e.en = 1'b0;
         tr[ab] = e;
         tr.push_back(mk(1, 0, 1, 1, 0, 0, e.li, e.rst ? 4'd0 : e.cnt));
         tr.push_back(mk(0, 0, 0, 0, 0, 0, e.li, 4'd0));
      end
      if (rs >= 0) begin
         e = tr[rs];
         tr = tr[0:rs];
         nc = e.rst ? 4'd0 : (e.en ? (e.ud ? e.cnt + 4'd1 : e.cnt - 4'd1) : e.cnt);
         tr.push_back(mk(0, 0, 0, 0, 0, 0, 4'd0, nc));
      end
      @(negedge clk);
      start = 1'b1; abort = 1'b0;
      top = 4'(t); dwell = 4'(d); loops = 4'(l);
      n = tr.size();
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         start = (k < n - 1 && tr[k].busy) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (k == rs) start = 1'b1;
         abort = (k == ab) || (tr[k].done && $urandom_range(0, 1) == 1);
         reset = (k == rs);
         top = 4'($urandom); dwell = 4'($urandom); loops = 4'($urandom);
         @(negedge clk);
         e = tr[k];
         chk($sformatf("%s c%0d ctrl", name, k),
             8'({busy, done, aborted, cnt_reset, cnt_enable, cnt_up_down}),
             8'({e.busy, e.done, e.ab, e.rst, e.en, e.ud}));
         chk($sformatf("%s c%0d loop_idx", name, k), 8'(loop_idx), 8'(e.li));
         chk($sformatf("%s c%0d count", name, k), 8'(count), 8'(e.cnt));
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      prev = tr[n - 1].cnt;
   endtask

   initial begin
      reset = 1'b1; ctr_clr = 1'b1; start = 1'b0; abort = 1'b0;
      top = 4'd0; dwell = 4'd0; loops = 4'd0;
      prev = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; ctr_clr = 1'b0;
      chk("reset ctrl", 8'({busy, done, aborted, cnt_reset, cnt_enable, cnt_up_down}), 8'd0);
      chk("reset loop_idx", 8'(loop_idx), 8'd0);

      // start and abort together in IDLE: nothing happens
      start = 1'b1; abort = 1'b1; top = 4'd3; dwell = 4'd1; loops = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start+abort ctrl", 8'({busy, done, aborted, cnt_reset, cnt_enable, cnt_up_down}), 8'd0);
      @(negedge clk);
      chk("start+abort busy", 8'(busy), 8'd0);

      run("t3d2l1",   3, 2, 1, -1, -1);
      run("t2d0l3",   2, 0, 3, -1, -1);
      run("t15d1l1", 15, 1, 1, -1, -1);
      run("l0",       4, 3, 0, -1, -1);
      run("t0",       0, 5, 2, -1, -1);
      run("abort_dn", 3, 2, 1,  8, -1);
      run("rst_dwl",  3, 5, 2, -1,  6);
      run("after_rst", 2, 1, 1, -1, -1);
      for (int i = 0; i < 12; i++)
         run($sformatf("rnd%0d", i), $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 3), -2, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
